// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes a MIPS instruction into ALU controls/operands
// and registers them into the ID/EX register, with load-use detection.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   id_valid, id_instr  instruction from ID
//   id_rs_data/rt_data  register-file operands
//   stall, flush        hold / squash the EX register
//   load_use            hazard request to upstream (combinational)
//   ex_*                registered ALU controls and operands for EX
module alu_issue_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         id_valid,
    input  logic [31:0]  id_instr,
    input  logic [N-1:0] id_rs_data,
    input  logic [N-1:0] id_rt_data,
    input  logic         stall,
    input  logic         flush,
    output logic         load_use,
    output logic         ex_valid,
    output logic [N-1:0] ex_a,
    output logic [N-1:0] ex_b,
    output logic [3:0]   ex_f,
    output logic [4:0]   ex_shamt,
    output logic [4:0]   ex_rd,
    output logic         ex_regwrite,
    output logic         ex_memread,
    output logic         ex_memwrite,
    output logic         ex_illegal
);

    localparam logic [3:0] F_ADD  = 4'b0000;
    localparam logic [3:0] F_SUB  = 4'b0001;
    localparam logic [3:0] F_AND  = 4'b0010;
    localparam logic [3:0] F_OR   = 4'b0011;
    localparam logic [3:0] F_XOR  = 4'b0100;
    localparam logic [3:0] F_SLL  = 4'b0101;
    localparam logic [3:0] F_SRL  = 4'b0110;
    localparam logic [3:0] F_SLLV = 4'b0111;
    localparam logic [3:0] F_SRA  = 4'b1000;
    localparam logic [3:0] F_SLT  = 4'b1001;

    typedef struct packed {
        logic         valid;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [3:0]   f;
        logic [4:0]   shamt;
        logic [4:0]   rd;
        logic         regwrite;
        logic         memread;
        logic         memwrite;
    } ex_t;

    localparam ex_t BUBBLE = '0;

    logic [5:0]   op;
    logic [5:0]   funct;
    logic [4:0]   rs_f;
    logic [4:0]   rt_f;
    logic [N-1:0] sext;
    logic [N-1:0] zext;
    logic         reads_rt;
    logic         legal;
    ex_t          dec;
    ex_t          ex_q;
    ex_t          ex_d;
    logic         ill_q;
    logic         ill_d;

    assign op    = id_instr[31:26];
    assign funct = id_instr[5:0];
    assign rs_f  = id_instr[25:21];
    assign rt_f  = id_instr[20:16];
    assign sext  = {{(N-16){id_instr[15]}}, id_instr[15:0]};
    assign zext  = {{(N-16){1'b0}}, id_instr[15:0]};

    assign reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);

    always_comb begin
        dec       = BUBBLE;
        legal     = 1'b1;
        dec.valid = 1'b1;
        dec.a     = id_rs_data;
        dec.b     = id_rt_data;
        case (op)
            6'h00: begin
                dec.rd       = id_instr[15:11];
                dec.regwrite = 1'b1;
                case (funct)
                    6'h20, 6'h21: dec.f = F_ADD;
                    6'h22, 6'h23: dec.f = F_SUB;
                    6'h24:        dec.f = F_AND;
                    6'h25:        dec.f = F_OR;
                    6'h26:        dec.f = F_XOR;
                    6'h2A:        dec.f = F_SLT;
                    6'h00, 6'h02, 6'h03: begin
                        dec.f     = (funct == 6'h00) ? F_SLL :
                                    (funct == 6'h02) ? F_SRL : F_SRA;
                        dec.a     = id_rt_data;
                        dec.b     = '0;
                        dec.shamt = id_instr[10:6];
                    end
                    6'h04: begin
                        dec.f     = F_SLLV;
                        dec.a     = id_rt_data;
                        dec.b     = '0;
                        dec.shamt = id_rs_data[4:0];
                    end
                    default: legal = 1'b0;
                endcase
            end
            6'h08, 6'h09, 6'h0A: begin
                dec.f        = (op == 6'h0A) ? F_SLT : F_ADD;
                dec.b        = sext;
                dec.rd       = rt_f;
                dec.regwrite = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec.f        = (op == 6'h0C) ? F_AND :
                               (op == 6'h0D) ? F_OR : F_XOR;
                dec.b        = zext;
                dec.rd       = rt_f;
                dec.regwrite = 1'b1;
            end
            6'h0F: begin
                dec.f        = F_SLL;
                dec.a        = zext;
                dec.b        = zext;
                dec.shamt    = 5'd16;
                dec.rd       = rt_f;
                dec.regwrite = 1'b1;
            end
            6'h23: begin
                dec.b        = sext;
                dec.rd       = rt_f;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
            end
            6'h2B: begin
                dec.b        = sext;
                dec.memwrite = 1'b1;
            end
            6'h04: dec.f = F_SUB;
            default: legal = 1'b0;
        endcase
        // a write to $0 is architecturally dead: drop it so it never
        // triggers a hazard or a writeback downstream
        if (!dec.regwrite || dec.rd == 5'd0) begin
            dec.regwrite = 1'b0;
            dec.rd       = 5'd0;
        end
    end

    assign load_use = id_valid && ex_q.valid && ex_q.memread &&
                      (ex_q.rd != 5'd0) &&
                      ((ex_q.rd == rs_f) ||
                       ((ex_q.rd == rt_f) && reads_rt));

    always_comb begin
        ex_d  = ex_q;
        ill_d = 1'b0;
        if (flush) begin
            ex_d = BUBBLE;
        end else if (stall) begin
            ex_d = ex_q;
        end else if (load_use || !id_valid) begin
            ex_d = BUBBLE;
        end else if (!legal) begin
            ex_d  = BUBBLE;
            ill_d = 1'b1;
        end else begin
            ex_d = dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= BUBBLE;
            ill_q <= 1'b0;
        end else begin
            ex_q  <= ex_d;
            ill_q <= ill_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_a        = ex_q.a;
    assign ex_b        = ex_q.b;
    assign ex_f        = ex_q.f;
    assign ex_shamt    = ex_q.shamt;
    assign ex_rd       = ex_q.rd;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memread  = ex_q.memread;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_illegal  = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed steps plus random traffic,
// checked against an instruction-level reference model.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        stall;
    logic        flush;
    logic        load_use;
    logic        ex_valid;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [3:0]  ex_f;
    logic [4:0]  ex_shamt;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_illegal;

    alu_issue_stage #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_instr(id_instr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .stall(stall), .flush(flush), .load_use(load_use),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_f(ex_f), .ex_shamt(ex_shamt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit        v;
        bit [31:0] a;
        bit [31:0] b;
        bit [3:0]  f;
        bit [4:0]  sh;
        bit [4:0]  rd;
        bit        rw;
        bit        mr;
        bit        mw;
        bit        ill;
        bit        bdc;
    } ex_t;

    ex_t exp_q;
    int  n_chk = 0;
    int  n_fail = 0;
    bit  last_lu = 0;

    bit [5:0] rfun [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                            6'h26, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h04,
                            6'h3F};
    bit [5:0] iops [11] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
                            6'h0F, 6'h23, 6'h2B, 6'h04, 6'h3F};

    function automatic bit [31:0] enc_r(bit [5:0] fn, bit [4:0] rs,
                                        bit [4:0] rt, bit [4:0] rd,
                                        bit [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic bit [31:0] enc_i(bit [5:0] op, bit [4:0] rs,
                                        bit [4:0] rt, bit [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference: what the instruction means, by mnemonic.
    function automatic void model_decode(input bit [31:0] ins,
                                         input bit [31:0] rs,
                                         input bit [31:0] rt,
                                         output ex_t e,
                                         output bit legal);
        bit [5:0]  op = ins[31:26];
        bit [5:0]  fn = ins[5:0];
        bit [31:0] se = 32'($signed(ins[15:0]));
        bit [31:0] ze = 32'(ins[15:0]);
        e = '0;
        legal = 1;
        e.v = 1;
        e.a = rs;
        e.b = rt;
        if (op == 6'h00) begin
            e.rd = ins[15:11];
            e.rw = 1;
            case (fn)
                6'h20, 6'h21: e.f = 0;
                6'h22, 6'h23: e.f = 1;
                6'h24: e.f = 2;
                6'h25: e.f = 3;
                6'h26: e.f = 4;
                6'h2A: e.f = 9;
                6'h00: begin e.f = 5; e.a = rt; e.sh = ins[10:6]; e.bdc = 1; end
                6'h02: begin e.f = 6; e.a = rt; e.sh = ins[10:6]; e.bdc = 1; end
                6'h03: begin e.f = 8; e.a = rt; e.sh = ins[10:6]; e.bdc = 1; end
                6'h04: begin e.f = 7; e.a = rt; e.sh = rs % 32; e.bdc = 1; end
                default: legal = 0;
            endcase
        end else begin
            e.rd = ins[20:16];
            e.rw = 1;
            case (op)
                6'h08, 6'h09: begin e.f = 0; e.b = se; end
                6'h0A: begin e.f = 9; e.b = se; end
                6'h0C: begin e.f = 2; e.b = ze; end
                6'h0D: begin e.f = 3; e.b = ze; end
                6'h0E: begin e.f = 4; e.b = ze; end
                6'h0F: begin e.f = 5; e.a = ze; e.sh = 16; e.bdc = 1; end
                6'h23: begin e.f = 0; e.b = se; e.mr = 1; end
                6'h2B: begin e.f = 0; e.b = se; e.mw = 1; e.rw = 0; end
                6'h04: begin e.f = 1; e.rw = 0; end
                default: legal = 0;
            endcase
        end
        if (!e.rw || e.rd == 0) begin
            e.rw = 0;
            e.rd = 0;
        end
    endfunction

    function automatic bit model_lu(bit v, bit [31:0] ins);
        bit rd_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) ||
                    (ins[31:26] == 6'h04);
        if (!(v && exp_q.v && exp_q.mr && exp_q.rd != 0)) return 0;
        return (exp_q.rd == ins[25:21]) ||
               (exp_q.rd == ins[20:16] && rd_rt);
    endfunction

    task automatic chk(input logic [31:0] got, input logic [31:0] want,
                       input string tag);
        n_chk++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        chk(32'(ex_valid), 32'(exp_q.v), {tag, ".valid"});
        chk(ex_a, exp_q.a, {tag, ".a"});
        if (!exp_q.bdc) chk(ex_b, exp_q.b, {tag, ".b"});
        chk(32'(ex_f), 32'(exp_q.f), {tag, ".f"});
        chk(32'(ex_shamt), 32'(exp_q.sh), {tag, ".shamt"});
        chk(32'(ex_rd), 32'(exp_q.rd), {tag, ".rd"});
        chk(32'(ex_regwrite), 32'(exp_q.rw), {tag, ".regwrite"});
        chk(32'(ex_memread), 32'(exp_q.mr), {tag, ".memread"});
        chk(32'(ex_memwrite), 32'(exp_q.mw), {tag, ".memwrite"});
        chk(32'(ex_illegal), 32'(exp_q.ill), {tag, ".illegal"});
    endtask

    task automatic step(input bit v, input bit [31:0] ins,
                        input bit [31:0] rs, input bit [31:0] rt,
                        input bit st, input bit fl, input string tag);
        bit  lu;
        bit  lg;
        ex_t d;
        id_valid   = v;
        id_instr   = ins;
        id_rs_data = rs;
        id_rt_data = rt;
        stall      = st;
        flush      = fl;
        #1;
        lu = model_lu(v, ins);
        chk(32'(load_use), 32'(lu), {tag, ".load_use"});
        model_decode(ins, rs, rt, d, lg);
        @(posedge clk);
        if (fl) exp_q = '0;
        else if (st) exp_q.ill = 0;
        else if (lu || !v) exp_q = '0;
        else if (!lg) begin exp_q = '0; exp_q.ill = 1; end
        else exp_q = d;
        #1;
        check_all(tag);
        last_lu = lu;
    endtask

    initial begin
        bit [31:0] ins;
        bit [31:0] rsd;
        bit [31:0] rtd;
        bit        v;
        bit        st;
        bit        fl;
        rst_n = 1; id_valid = 0; id_instr = 0;
        id_rs_data = 0; id_rt_data = 0; stall = 0; flush = 0;
        exp_q = '0;
        #1 rst_n = 0;
        #2;
        check_all("reset");
        chk(32'(load_use), 32'd0, "reset.load_use");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        step(1, enc_r(6'h20, 1, 2, 3, 0), 5, 7, 0, 0, "add");
        chk(ex_a, 32'd5, "add.a_const");
        chk(ex_b, 32'd7, "add.b_const");
        chk(32'(ex_rd), 32'd3, "add.rd_const");
        step(1, enc_r(6'h03, 0, 2, 4, 3), 0, 32'h80000000, 0, 0, "sra");
        chk(32'(ex_f), 32'h8, "sra.f_const");
        chk(ex_a, 32'h80000000, "sra.a_const");
        chk(32'(ex_shamt), 32'd3, "sra.shamt_const");
        step(1, enc_i(6'h08, 1, 7, 16'hFFFF), 9, 0, 0, 0, "addi");
        chk(ex_b, 32'hFFFFFFFF, "addi.b_const");
        step(1, enc_i(6'h0D, 1, 7, 16'hFFFF), 9, 0, 0, 0, "ori");
        chk(ex_b, 32'h0000FFFF, "ori.b_const");
        step(1, enc_i(6'h0F, 0, 8, 16'h1234), 9, 0, 0, 0, "lui");
        chk(ex_a, 32'h00001234, "lui.a_const");
        chk(32'(ex_f), 32'h5, "lui.f_const");
        chk(32'(ex_shamt), 32'd16, "lui.shamt_const");

        step(1, enc_i(6'h23, 1, 5, 16'h0010), 100, 0, 0, 0, "lw5");
        step(1, enc_r(6'h20, 5, 1, 6, 0), 3, 4, 0, 0, "lu_hit");
        chk(32'(last_lu), 32'd1, "lu_hit.model");
        chk(32'(ex_valid), 32'd0, "lu_hit.bubble");
        step(1, enc_r(6'h20, 5, 1, 6, 0), 3, 4, 0, 0, "lu_retry");
        chk(32'(ex_valid), 32'd1, "lu_retry.valid");
        step(1, enc_i(6'h23, 1, 0, 16'h0004), 100, 0, 0, 0, "lw0");
        step(1, enc_r(6'h20, 0, 1, 6, 0), 3, 4, 0, 0, "lu_rd0");
        step(1, enc_i(6'h08, 1, 0, 16'h0001), 3, 0, 0, 0, "addi0");
        chk(32'(ex_regwrite), 32'd0, "addi0.rw_const");

        step(1, enc_r(6'h22, 1, 2, 9, 0), 50, 8, 0, 0, "sub");
        for (int k = 0; k < 3; k++)
            step(1, enc_r(6'h24, 3, 4, 10, 0), 1, 2, 1, 0, "stall");
        chk(32'(ex_f), 32'h1, "stall.f_const");
        step(1, enc_r(6'h24, 3, 4, 10, 0), 1, 2, 1, 1, "flush_stall");
        chk(32'(ex_valid), 32'd0, "flush_stall.valid_const");

        step(1, enc_i(6'h3F, 1, 2, 16'h0000), 1, 2, 0, 0, "illegal");
        chk(32'(ex_illegal), 32'd1, "illegal.pulse");
        step(0, 32'h0, 0, 0, 0, 0, "illegal_end");
        chk(32'(ex_illegal), 32'd0, "illegal.clear");

        for (int k = 0; k < 400; k++) begin
            if (!last_lu) begin
                if ($urandom_range(0, 1) == 0)
                    ins = enc_r(rfun[$urandom_range(0, 12)],
                                5'($urandom_range(0, 3)),
                                5'($urandom_range(0, 3)),
                                5'($urandom_range(0, 3)),
                                5'($urandom));
                else
                    ins = enc_i(iops[$urandom_range(0, 10)],
                                5'($urandom_range(0, 3)),
                                5'($urandom_range(0, 3)),
                                16'($urandom));
                rsd = $urandom;
                rtd = $urandom;
                v = ($urandom_range(0, 7) != 0);
            end
            st = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 15) == 0);
            step(v, ins, rsd, rtd, st, fl, "rand");
        end

        step(1, enc_r(6'h25, 1, 2, 11, 0), 6, 9, 0, 0, "pre_rst");
        #2 rst_n = 0;
        #1;
        exp_q = '0;
        check_all("async_rst");
        chk(32'(load_use), 32'd0, "async_rst.load_use");
        #2 rst_n = 1;
        step(1, enc_r(6'h26, 1, 2, 12, 0), 6, 9, 0, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
